// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit: fetch stage of the my86 pipeline.
// Reads Y86-64 instructions one byte per beat, assembles icode/ifun/rA/rB/valC,
// computes valP and the predicted next PC, and presents them to the decode
// register with f_valid_o. Redirects restart the fetch at a new PC.
// Optional build macro FETCH_BOUND_CHECK_EN: addresses >= IMEM_BYTES are never
// requested and the fetch ends with SADR instead.
module y86_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        F_stall_i,
  input  logic        F_redirect_i,
  input  logic [63:0] F_redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [7:0]  imem_rdata_i,
  input  logic        imem_err_i,
  output logic [3:0]  f_icode_o,
  output logic [3:0]  f_ifun_o,
  output logic [3:0]  f_rA_o,
  output logic [3:0]  f_rB_o,
  output logic [63:0] f_valC_o,
  output logic [63:0] f_valP_o,
  output logic [3:0]  f_stat_o,
  output logic        f_valid_o,
  output logic [63:0] f_predPC_o
);

  localparam logic [2:0] S_OP    = 3'd0;
  localparam logic [2:0] S_REG   = 3'd1;
  localparam logic [2:0] S_CONST = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [3:0] SAOK  = 4'd1;
  localparam logic [3:0] SHLT  = 4'd2;
  localparam logic [3:0] SADR  = 4'd3;
  localparam logic [3:0] SINS  = 4'd4;
  localparam logic [3:0] RNONE = 4'hF;

  // irmovq, rmmovq and mrmovq carry both a register byte and a constant
  function automatic logic has_reg_and_const(input logic [3:0] icode);
    return (icode == 4'h3) || (icode == 4'h4) || (icode == 4'h5);
  endfunction

  // jXX and call predict their constant target
  function automatic logic is_jump(input logic [3:0] icode);
    return (icode == 4'h7) || (icode == 4'h8);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, rA_q, rA_d, rB_q, rB_d;
  logic [63:0] valC_q, valC_d, valP_q, valP_d, predPC_q, predPC_d;
  logic [3:0]  stat_q, stat_d;
  logic        valid_q, valid_d;

  logic        fetching, bound_err, beat, addr_err;
  logic [3:0]  byte_idx;
  logic [63:0] fetch_addr, valC_merge;
  logic [5:0]  byte_sh;
  logic        fin;
  logic [3:0]  fin_len, fin_stat;

  assign fetching = (state_q == S_OP) || (state_q == S_REG) || (state_q == S_CONST);

  // byte offset of the current beat within the instruction
  always_comb begin
    byte_idx = 4'd0;
    case (state_q)
      S_REG:   byte_idx = 4'd1;
      S_CONST: byte_idx = (has_reg_and_const(icode_q) ? 4'd2 : 4'd1) + {1'b0, cnt_q};
      default: byte_idx = 4'd0;
    endcase
  end

  assign fetch_addr = pc_q + 64'(byte_idx);

`ifdef FETCH_BOUND_CHECK_EN
  assign bound_err = fetching && (fetch_addr >= 64'(IMEM_BYTES));
`else
  assign bound_err = 1'b0;
`endif

  assign imem_req_o  = !rst_i && fetching && !bound_err;
  assign imem_addr_o = fetch_addr;
  assign beat        = imem_req_o & imem_ready_i;
  // an out-of-range address behaves exactly like an error beat
  assign addr_err    = (beat & imem_err_i) | bound_err;

  assign byte_sh    = {cnt_q, 3'b000};
  assign valC_merge = (valC_q & ~(64'hFF << byte_sh)) | (64'(imem_rdata_i) << byte_sh);

  // next-state and field assembly
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    rA_d     = rA_q;
    rB_d     = rB_q;
    valC_d   = valC_q;
    valP_d   = valP_q;
    predPC_d = predPC_q;
    stat_d   = stat_q;
    valid_d  = valid_q;
    fin      = 1'b0;
    fin_len  = 4'd0;
    fin_stat = SAOK;

    if (F_redirect_i) begin
      pc_d    = F_redirect_pc_i;
      state_d = S_OP;
      valid_d = 1'b0;
    end else begin
      if (fetching && addr_err) begin
        fin      = 1'b1;
        fin_len  = 4'd0;
        fin_stat = SADR;
        icode_d  = 4'h1;
        ifun_d   = 4'h0;
        rA_d     = RNONE;
        rB_d     = RNONE;
        valC_d   = 64'd0;
      end else begin
        case (state_q)
          S_OP: if (beat) begin
            icode_d = imem_rdata_i[7:4];
            ifun_d  = imem_rdata_i[3:0];
            rA_d    = RNONE;
            rB_d    = RNONE;
            valC_d  = 64'd0;
            cnt_d   = 3'd0;
            case (imem_rdata_i[7:4])
              4'h0, 4'h1, 4'h9: begin
                fin      = 1'b1;
                fin_len  = 4'd1;
                fin_stat = (imem_rdata_i[7:4] == 4'h0) ? SHLT : SAOK;
              end
              4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: state_d = S_REG;
              4'h7, 4'h8: state_d = S_CONST;
              default: begin
                fin      = 1'b1;
                fin_len  = 4'd1;
                fin_stat = SINS;
                icode_d  = 4'h1;
                ifun_d   = 4'h0;
              end
            endcase
          end
          S_REG: if (beat) begin
            rA_d = imem_rdata_i[7:4];
            rB_d = imem_rdata_i[3:0];
            if (has_reg_and_const(icode_q)) begin
              state_d = S_CONST;
              cnt_d   = 3'd0;
            end else begin
              fin     = 1'b1;
              fin_len = 4'd2;
            end
          end
          S_CONST: if (beat) begin
            valC_d = valC_merge;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              fin     = 1'b1;
              fin_len = has_reg_and_const(icode_q) ? 4'd10 : 4'd9;
            end
          end
          S_HOLD: if (!F_stall_i) begin
            valid_d = 1'b0;
            if (stat_q == SAOK) begin
              pc_d    = predPC_q;
              state_d = S_OP;
            end else begin
              state_d = S_STOP;
            end
          end
          S_STOP:  state_d = S_STOP;
          default: state_d = S_OP;
        endcase
      end

      if (fin) begin
        state_d  = S_HOLD;
        valid_d  = 1'b1;
        stat_d   = fin_stat;
        valP_d   = pc_q + 64'(fin_len);
        predPC_d = is_jump(icode_d) ? valC_d : (pc_q + 64'(fin_len));
      end
    end
  end

  // state and presented-field registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_OP;
      pc_q     <= RESET_PC;
      cnt_q    <= 3'd0;
      icode_q  <= 4'h0;
      ifun_q   <= 4'h0;
      rA_q     <= RNONE;
      rB_q     <= RNONE;
      valC_q   <= 64'd0;
      valP_q   <= 64'd0;
      predPC_q <= RESET_PC;
      stat_q   <= SAOK;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      icode_q  <= icode_d;
      ifun_q   <= ifun_d;
      rA_q     <= rA_d;
      rB_q     <= rB_d;
      valC_q   <= valC_d;
      valP_q   <= valP_d;
      predPC_q <= predPC_d;
      stat_q   <= stat_d;
      valid_q  <= valid_d;
    end
  end

  assign f_icode_o  = icode_q;
  assign f_ifun_o   = ifun_q;
  assign f_rA_o     = rA_q;
  assign f_rB_o     = rB_q;
  assign f_valC_o   = valC_q;
  assign f_valP_o   = valP_q;
  assign f_stat_o   = stat_q;
  assign f_valid_o  = valid_q;
  assign f_predPC_o = predPC_q;

endmodule
